// File: rtl/mul_32_3_pkg.sv
// Shared constants and FSM state type for the 3*Q+R reconstruction multiplier.
package mul_32_3_pkg;
   localparam int DIGIT_W  = 6;
   localparam int N_DIGITS = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/mul_32_3_mul3_digit.sv
// One radix-64 digit step: sum/carry = 3*digit + cin (at most 192 fits in 8 bits).
module mul3_digit
   import mul_32_3_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   input  logic [1:0]         cin,
   output logic [DIGIT_W-1:0] sum,
   output logic [1:0]         cout
);
   logic [DIGIT_W+1:0] s_s;

   // 3*d formed as d + 2*d
   always_comb begin
      s_s  = {2'b00, digit} + {1'b0, digit, 1'b0} + {{DIGIT_W{1'b0}}, cin};
      sum  = s_s[DIGIT_W-1:0];
      cout = s_s[DIGIT_W+1:DIGIT_W];
   end
endmodule

// File: rtl/mul_32_3.sv
// Reconstructs X = 3*Q + R (mod 2^32) one 6-bit digit per cycle, flagging invalid pairs in err.
module mul_32_3
   import mul_32_3_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:1] Q,
   input  logic [2:1]  R,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [32:1] X,
   output logic        err
);
   state_t             state_q, state_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [1:0]         carry_q, carry_d;
   logic [31:1]        q_q, q_d;
   logic [32:1]        x_q, x_d;
   logic               err_q, err_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [DIGIT_W-1:0] digit_s, sum_s;
   logic [1:0]         cout_s;

   mul3_digit u_digit (
      .digit (digit_s),
      .cin   (carry_q),
      .sum   (sum_s),
      .cout  (cout_s)
   );

   // Next-state, datapath and handshake decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      q_d     = q_q;
      x_d     = x_q;
      err_d   = err_q;

      case (cnt_q)
         3'd0:    digit_s = q_q[6:1];
         3'd1:    digit_s = q_q[12:7];
         3'd2:    digit_s = q_q[18:13];
         3'd3:    digit_s = q_q[24:19];
         3'd4:    digit_s = q_q[30:25];
         default: digit_s = {5'b00000, q_q[31]};
      endcase

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               q_d     = Q;
               carry_d = R;
               cnt_d   = 3'd0;
               x_d     = 32'h0000_0000;
               err_d   = (R == 2'd3);
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            case (cnt_q)
               3'd0:    x_d[6:1]   = sum_s;
               3'd1:    x_d[12:7]  = sum_s;
               3'd2:    x_d[18:13] = sum_s;
               3'd3:    x_d[24:19] = sum_s;
               3'd4:    x_d[30:25] = sum_s;
               default: x_d[32:31] = sum_s[1:0];
            endcase
            if (cnt_q == 3'(N_DIGITS - 1)) begin
               // final 1-bit digit: anything past bit 32 is overflow
               err_d   = err_q | sum_s[2];
               state_d = DONE;
            end else begin
               carry_d = cout_s;
               cnt_d   = cnt_q + 3'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   // All state, with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         carry_q     <= 2'd0;
         q_q         <= 31'd0;
         x_q         <= 32'h0000_0000;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         q_q         <= q_d;
         x_q         <= x_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign X         = x_q;
   assign err       = err_q;
endmodule
